// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: decoder control, ROM port and the instruction handed to decode.
// The master modport is the fetch unit; the slave modport is the surrounding core/ROM.
interface instr_fetch_if #(
   parameter int ADDR_W  = 6,
   parameter int INSTR_W = 20
);
   logic               start;
   logic               stall;
   logic               branch_en;
   logic [ADDR_W-1:0]  branch_target;
   logic               halt_req;
   logic [ADDR_W-1:0]  rom_addr;
   logic               rom_we;
   logic [INSTR_W-1:0] rom_din;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               halted;

   modport master (
      input  start, stall, branch_en, branch_target, halt_req, rom_din,
      output rom_addr, rom_we, instr, instr_pc, instr_valid, halted
   );

   modport slave (
      output start, stall, branch_en, branch_target, halt_req, rom_din,
      input  rom_addr, rom_we, instr, instr_pc, instr_valid, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer in front of a 1-cycle registered-read ROM.
// pc_q always names the address whose data is currently on rom_din.
module instr_fetch #(
   parameter int          ADDR_W   = 6,
   parameter int          INSTR_W  = 20,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   logic [1:0]        state, state_d;
   logic [ADDR_W-1:0] pc_q, nxt;
   logic              valid_q, valid_d;
   logic              accept;

   assign accept = valid_q & ~bus.stall;

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      nxt     = pc_q;
      state_d = state;
      valid_d = 1'b0;
      if (rst) begin
         nxt     = PC_RST;
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: begin
               nxt = PC_RST;
               if (bus.start) begin
                  state_d = RUN;
                  valid_d = 1'b1;
               end
            end
            RUN: begin
               if (accept && bus.branch_en) begin
                  // Branch outranks a simultaneous halt; the halt is dropped.
                  nxt     = bus.branch_target;
                  valid_d = 1'b1;
               end else if (accept && bus.halt_req) begin
                  nxt     = pc_q;
                  state_d = HALT;
               end else if (bus.stall && valid_q) begin
                  // Re-read the same word so rom_din stays stable next cycle.
                  nxt     = pc_q;
                  valid_d = 1'b1;
               end else begin
                  nxt     = pc_q + ADDR_W'(1);
                  valid_d = 1'b1;
               end
            end
            HALT: begin
               if (bus.start) begin
                  // The halting word was already accepted, so resume past it.
                  nxt     = pc_q + ADDR_W'(1);
                  state_d = RUN;
                  valid_d = 1'b1;
               end
            end
            default: begin
               nxt     = PC_RST;
               state_d = IDLE;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc_q    <= PC_RST;
         valid_q <= 1'b0;
      end else begin
         state   <= state_d;
         pc_q    <= nxt;
         valid_q <= valid_d;
      end
   end

   assign bus.rom_addr    = nxt;
   assign bus.rom_we      = 1'b0;
   assign bus.instr       = INSTR_W'(bus.rom_din);
   assign bus.instr_pc    = pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural 64x20 ROM, one task per scenario,
// expectations pushed per cycle and popped after the following clock edge.
module tb_instr_fetch;

   localparam int ADDR_W  = 6;
   localparam int INSTR_W = 20;

   typedef struct packed {
      logic              valid;
      logic              halted;
      logic [ADDR_W-1:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic [INSTR_W-1:0] rom [0:(1<<ADDR_W)-1];
   logic [INSTR_W-1:0] rom_q;

   instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_q <= rom[bus.rom_addr];
   assign bus.rom_din = rom_q;

   // Push one expectation, advance one clock, then pop and compare it.
   task automatic step(input logic v, input logic h, input int pc, input string name);
      exp_t e, got;
      sb.push_back('{valid: v, halted: h, pc: ADDR_W'(pc)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got = '{valid: bus.instr_valid, halted: bus.halted, pc: bus.instr_pc};
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL %s: got valid=%0b halted=%0b pc=%0d, want valid=%0b halted=%0b pc=%0d",
                  name, got.valid, got.halted, got.pc, e.valid, e.halted, e.pc);
      end
      n_cmp++;
      if (bus.instr !== INSTR_W'(e.pc)) begin
         n_err++;
         $display("FAIL %s.instr: got %0d want %0d", name, bus.instr, e.pc);
      end
      n_cmp++;
      if (bus.rom_we !== 1'b0) begin
         n_err++;
         $display("FAIL %s.rom_we: got %b want 0", name, bus.rom_we);
      end
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.stall = 0; bus.branch_en = 0; bus.halt_req = 0;
      bus.branch_target = '0;
   endtask

   task automatic branch_to(input int tgt, input string name);
      bus.branch_en = 1; bus.branch_target = ADDR_W'(tgt);
      step(1, 0, tgt, name);
      bus.branch_en = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rom_addr !== '0) begin
         n_err++;
         $display("FAIL reset.rom_addr: got %0d want 0", bus.rom_addr);
      end
      step(0, 0, 0, "reset");
      rst = 0;
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle2");
   endtask

   task automatic test_sequential();
      bus.start = 1;
      step(1, 0, 0, "start");
      step(1, 0, 1, "start_in_run");
      bus.start = 0;
      for (int i = 2; i <= 5; i++) step(1, 0, i, "seq");
   endtask

   task automatic test_stall();
      bus.stall = 1;
      for (int i = 0; i < 3; i++) step(1, 0, 5, "stall_hold");
      bus.stall = 0;
      step(1, 0, 6, "stall_release");
   endtask

   task automatic test_branch();
      for (int i = 7; i <= 10; i++) step(1, 0, i, "to10");
      bus.stall = 1; bus.branch_en = 1; bus.branch_target = 6'd40;
      step(1, 0, 10, "branch_stalled");
      bus.stall = 0;
      step(1, 0, 40, "branch");
      bus.branch_en = 0;
      step(1, 0, 41, "after_branch");
   endtask

   task automatic test_halt();
      branch_to(20, "to20");
      bus.halt_req = 1;
      step(0, 1, 20, "halt");
      bus.halt_req = 0;
      bus.stall = 1;
      for (int i = 0; i < 3; i++) step(0, 1, 20, "halt_hold");
      bus.stall = 0;
      bus.start = 1;
      step(1, 0, 21, "resume");
      bus.start = 0;
      step(1, 0, 22, "resume_next");
   endtask

   task automatic test_wrap();
      branch_to(62, "to62");
      step(1, 0, 63, "wrap63");
      step(1, 0, 0, "wrap0");
      step(1, 0, 1, "wrap1");
      bus.halt_req = 1;
      branch_to(30, "branch_over_halt");
      bus.halt_req = 0;
      step(1, 0, 31, "no_halt");
   endtask

   task automatic test_reset_mid();
      branch_to(33, "to33");
      bus.stall = 1; rst = 1;
      step(0, 0, 0, "mid_reset");
      rst = 0; bus.stall = 0;
      step(0, 0, 0, "post_reset_idle");
      bus.start = 1;
      step(1, 0, 0, "restart");
      bus.start = 0;
      step(1, 0, 1, "restart_next");
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = INSTR_W'(i);
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
